// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: prioritises M-stage exceptions, redirects the PC,
// and keeps Status/Cause/EPC/BadVAddr/Count/Compare.
module cp0_exc_ctrl #(
    parameter int          EXT_INT_W   = 6,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXT_INT_W-1:0] ext_int,
    input  logic                 stall,
    input  logic                 inst_valid,
    input  logic [31:0]          pc,
    input  logic [31:0]          badaddr,
    input  logic                 in_delayslot,
    input  logic                 adel_pc,
    input  logic                 adel_ld,
    input  logic                 ades,
    input  logic                 ri,
    input  logic                 sys,
    input  logic                 brk,
    input  logic                 ov,
    input  logic                 eret,
    input  logic                 mtc0_en,
    input  logic [4:0]           mtc0_addr,
    input  logic [31:0]          mtc0_data,
    input  logic [4:0]           mfc0_addr,
    output logic [31:0]          mfc0_data,
    output logic                 exc_valid,
    output logic [4:0]           exc_code,
    output logic                 flush,
    output logic [31:0]          pc_target,
    output logic [31:0]          status_o,
    output logic [31:0]          cause_o,
    output logic [31:0]          epc_o,
    output logic                 timer_int
);
    localparam int HW_IP_W = (EXT_INT_W < 6) ? EXT_INT_W : 6;

    logic [SYNC_STAGES-1:0][EXT_INT_W-1:0] sync_q;
    logic        toggle_q, toggle_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d;
    logic        bd_q, bd_d, ti_q, ti_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;

    logic [5:0]  ip_hw;
    logic [7:0]  ip;
    logic        int_pending, commit, exc_any, is_eret;
    logic        take_exc, take_eret, cp0_wr;
    logic [4:0]  code;

    always_comb begin
        ip_hw = '0;
        for (int i = 0; i < HW_IP_W; i++) ip_hw[i] = sync_q[SYNC_STAGES-1][i];
        ip_hw[5] = ip_hw[5] | ti_q;
    end

    assign ip          = {ip_hw, ip_sw_q};
    assign int_pending = ie_q & ~exl_q & (|(im_q & ip));
    assign commit      = inst_valid & ~stall & ~rst;

    always_comb begin
        exc_any = 1'b1;
        is_eret = 1'b0;
        code    = 5'h00;
        if (int_pending)            code = 5'h00;
        else if (adel_pc | adel_ld) code = 5'h04;
        else if (ri)                code = 5'h0A;
        else if (sys)               code = 5'h08;
        else if (brk)               code = 5'h09;
        else if (ades)              code = 5'h05;
        else if (ov)                code = 5'h0C;
        else if (eret) begin
            code    = 5'h0E;
            is_eret = 1'b1;
        end else begin
            exc_any = 1'b0;
        end
    end

    assign exc_valid = commit & exc_any;
    assign flush     = exc_valid;
    assign exc_code  = exc_valid ? code : 5'h00;
    assign pc_target = !exc_valid ? 32'h0 : (is_eret ? epc_q : EXC_VECTOR);
    assign take_exc  = exc_valid & ~is_eret;
    assign take_eret = exc_valid & is_eret;
    // A redirect in flight owns CP0 this cycle, so a coincident mtc0 is dropped.
    assign cp0_wr    = mtc0_en & ~stall & ~exc_valid;

    assign status_o  = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o   = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};
    assign epc_o     = epc_q;
    assign timer_int = ti_q & ~rst;

    always_comb begin
        case (mfc0_addr)
            5'd8:    mfc0_data = badvaddr_q;
            5'd9:    mfc0_data = count_q;
            5'd11:   mfc0_data = compare_q;
            5'd12:   mfc0_data = status_o;
            5'd13:   mfc0_data = cause_o;
            5'd14:   mfc0_data = epc_q;
            default: mfc0_data = 32'h0;
        endcase
    end

    always_comb begin
        toggle_d   = ~toggle_q;
        count_d    = count_q + {31'b0, toggle_q};
        compare_d  = compare_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q | (count_q == compare_q);
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;

        if (cp0_wr) begin
            case (mtc0_addr)
                5'd9:  count_d = mtc0_data;
                5'd11: begin
                    compare_d = mtc0_data;
                    ti_d      = 1'b0;
                end
                5'd12: begin
                    im_d  = mtc0_data[15:8];
                    exl_d = mtc0_data[1];
                    ie_d  = mtc0_data[0];
                end
                5'd13: ip_sw_d = mtc0_data[9:8];
                5'd14: epc_d   = mtc0_data;
                default: ;
            endcase
        end

        if (take_exc) begin
            exl_d     = 1'b1;
            exccode_d = code;
            // Nested exception: keep the original return point.
            if (!exl_q) begin
                bd_d  = in_delayslot;
                epc_d = in_delayslot ? pc - 32'd4 : pc;
            end
            if (code == 5'h04)      badvaddr_d = adel_pc ? pc : badaddr;
            else if (code == 5'h05) badvaddr_d = badaddr;
        end

        if (take_eret) exl_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            toggle_q   <= 1'b0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= 2'b0;
            exccode_q  <= 5'h0;
        end else begin
            sync_q[0] <= ext_int;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            toggle_q   <= toggle_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
        end
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus a per-cycle reference model of CP0.
module tb_cp0_exc_ctrl;
    localparam int          W   = 6;
    localparam int          SS  = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic          clk, rst;
    logic [W-1:0]  ext_int;
    logic          stall, inst_valid, in_delayslot;
    logic [31:0]   pc, badaddr, mtc0_data, mfc0_data, pc_target, status_o, cause_o, epc_o;
    logic          adel_pc, adel_ld, ades, ri, sys, brk, ov, eret;
    logic          mtc0_en, exc_valid, flush, timer_int;
    logic [4:0]    mtc0_addr, mfc0_addr, exc_code;

    cp0_exc_ctrl #(.EXT_INT_W(W), .EXC_VECTOR(VEC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .ext_int(ext_int), .stall(stall), .inst_valid(inst_valid),
        .pc(pc), .badaddr(badaddr), .in_delayslot(in_delayslot),
        .adel_pc(adel_pc), .adel_ld(adel_ld), .ades(ades), .ri(ri), .sys(sys),
        .brk(brk), .ov(ov), .eret(eret),
        .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
        .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
        .exc_valid(exc_valid), .exc_code(exc_code), .flush(flush), .pc_target(pc_target),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .timer_int(timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic         m_valid = 1'b0;
    logic [7:0]   m_im;
    logic         m_exl, m_ie, m_bd, m_ti, m_phase;
    logic [1:0]   m_ipsw;
    logic [4:0]   m_code;
    logic [31:0]  m_epc, m_bad, m_count, m_cmp;
    logic [W-1:0] m_sync[$];

    function automatic logic [4:0] rank_code(input int r);
        case (r)
            0: return 5'h00;  1: return 5'h04;  2: return 5'h0A;  3: return 5'h08;
            4: return 5'h09;  5: return 5'h05;  6: return 5'h0C;  default: return 5'h0E;
        endcase
    endfunction

    always @(negedge clk) begin : cmp_p
        logic [5:0]  hw;
        logic [7:0]  ip8, req;
        logic        pend, e_valid, e_eret, wr, n_ti;
        logic [4:0]  e_code;
        logic [31:0] e_target, x_status, x_cause, x_mfc0, n_count;
        if (rst) begin
            chk("rst_exc_valid", exc_valid, 0);
            chk("rst_flush", flush, 0);
            chk("rst_exc_code", exc_code, 0);
            chk("rst_pc_target", pc_target, 0);
            chk("rst_timer_int", timer_int, 0);
            if (m_valid) begin
                chk("rst_status", status_o, 32'h0040_0000);
                chk("rst_cause", cause_o, 0);
                chk("rst_epc", epc_o, 0);
            end
            m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_phase = 0;
            m_ipsw = 0; m_code = 0; m_epc = 0; m_bad = 0; m_count = 0; m_cmp = 0;
            m_sync = {};
            for (int s = 0; s < SS; s++) m_sync.push_back('0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            hw = '0;
            for (int i = 0; i < 6 && i < W; i++) hw[i] = m_sync[SS-1][i];
            hw[5] = hw[5] | m_ti;
            ip8  = {hw, m_ipsw};
            pend = m_ie && !m_exl && ((m_im & ip8) != 0);
            req  = {pend, adel_pc | adel_ld, ri, sys, brk, ades, ov, eret};
            e_valid = 0; e_eret = 0; e_code = 0;
            for (int r = 0; r < 8; r++)
                if (!e_valid && req[7-r]) begin
                    e_valid = 1; e_code = rank_code(r); e_eret = (r == 7);
                end
            if (!(inst_valid && !stall)) begin
                e_valid = 0; e_code = 0;
            end
            e_target = !e_valid ? 32'h0 : (e_eret ? m_epc : VEC);
            x_status = 32'h0040_0000 | ({24'b0, m_im} << 8) | {30'b0, m_exl, m_ie};
            x_cause  = {m_bd, m_ti, 14'b0, ip8, 1'b0, m_code, 2'b0};
            case (mfc0_addr)
                5'd8: x_mfc0 = m_bad;      5'd9: x_mfc0 = m_count;
                5'd11: x_mfc0 = m_cmp;     5'd12: x_mfc0 = x_status;
                5'd13: x_mfc0 = x_cause;   5'd14: x_mfc0 = m_epc;
                default: x_mfc0 = 0;
            endcase
            chk("exc_valid", exc_valid, e_valid);
            chk("flush", flush, e_valid);
            chk("exc_code", exc_code, e_code);
            chk("pc_target", pc_target, e_target);
            chk("status", status_o, x_status);
            chk("cause", cause_o, x_cause);
            chk("epc", epc_o, m_epc);
            chk("timer_int", timer_int, m_ti);
            chk("mfc0_data", mfc0_data, x_mfc0);

            wr      = mtc0_en && !stall && !e_valid;
            n_count = m_count + (m_phase ? 32'd1 : 32'd0);
            n_ti    = (wr && mtc0_addr == 5'd11) ? 1'b0 : ((m_count == m_cmp) ? 1'b1 : m_ti);
            m_phase = !m_phase;
            if (e_valid && e_eret) m_exl = 0;
            else if (e_valid) begin
                if (!m_exl) begin
                    m_bd  = in_delayslot;
                    m_epc = in_delayslot ? pc - 32'd4 : pc;
                end
                m_exl  = 1;
                m_code = e_code;
                if (e_code == 5'h04) m_bad = adel_pc ? pc : badaddr;
                else if (e_code == 5'h05) m_bad = badaddr;
            end
            if (wr) begin
                case (mtc0_addr)
                    5'd9:  n_count = mtc0_data;
                    5'd11: m_cmp = mtc0_data;
                    5'd12: begin m_im = mtc0_data[15:8]; m_exl = mtc0_data[1]; m_ie = mtc0_data[0]; end
                    5'd13: m_ipsw = mtc0_data[9:8];
                    5'd14: m_epc = mtc0_data;
                    default: ;
                endcase
            end
            m_count = n_count;
            m_ti    = n_ti;
            m_sync.push_front(ext_int);
            void'(m_sync.pop_back());
        end
    end

    // ---------------- driver ----------------
    logic [4:0] rot_tab [8];
    int         rot_i = 0;

    task automatic clr();
        ext_int = '0; stall = 0; inst_valid = 0; pc = 0; badaddr = 0; in_delayslot = 0;
        adel_pc = 0; adel_ld = 0; ades = 0; ri = 0; sys = 0; brk = 0; ov = 0; eret = 0;
        mtc0_en = 0; mtc0_addr = 0; mtc0_data = 0;
        mfc0_addr = rot_tab[rot_i % 8];
        rot_i++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        clr();
        mtc0_en = 1; mtc0_addr = a; mtc0_data = d;
        tick();
        clr();
    endtask

    task automatic do_eret();
        clr();
        inst_valid = 1; eret = 1;
        tick();
        clr();
    endtask

    logic [7:0] vec_tab  [8];
    logic [4:0] code_tab [8];
    logic       val_tab  [8];
    int         waited;
    logic       found;

    initial begin
        rot_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd10, 5'd0};
        vec_tab  = '{8'b1000_0001, 8'b0011_1111, 8'b0001_1111, 8'b0000_1111,
                     8'b0000_0111, 8'b0000_0011, 8'b0000_0000, 8'b0000_0001};
        code_tab = '{5'h04, 5'h0A, 5'h08, 5'h09, 5'h05, 5'h0C, 5'h00, 5'h0E};
        val_tab  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        clr();
        rst = 1;
        tick();
        tick();
        chk("lit_rst_status", status_o, 32'h0040_0000);
        chk("lit_rst_cause", cause_o, 0);
        chk("lit_rst_epc", epc_o, 0);
        chk("lit_rst_timer", timer_int, 0);
        rst = 0;

        wr0(5'd11, 32'hFFFF_0000);

        // ri in a delay slot
        clr(); inst_valid = 1; ri = 1; pc = 32'hBFC0_1000; in_delayslot = 1;
        #1;
        chk("lit_ri_code", exc_code, 5'h0A);
        chk("lit_ri_target", pc_target, 32'hBFC0_0380);
        tick(); clr();
        chk("lit_ri_epc", epc_o, 32'hBFC0_0FFC);
        chk("lit_ri_bd", cause_o[31], 1);
        chk("lit_ri_exl", status_o[1], 1);
        chk("lit_ri_cause_code", cause_o[6:2], 5'h0A);

        clr(); inst_valid = 1; eret = 1;
        #1;
        chk("lit_eret1_target", pc_target, 32'hBFC0_0FFC);
        tick(); clr();
        chk("lit_eret1_exl", status_o[1], 0);

        // load address error, then again while EXL is set
        clr(); inst_valid = 1; adel_ld = 1; badaddr = 32'h8000_0003; pc = 32'h8000_1000;
        #1;
        chk("lit_adel_code", exc_code, 5'h04);
        tick(); clr(); mfc0_addr = 5'd8;
        #1;
        chk("lit_adel_badv", mfc0_data, 32'h8000_0003);
        chk("lit_adel_epc", epc_o, 32'h8000_1000);
        clr(); inst_valid = 1; adel_ld = 1; badaddr = 32'h8000_0007; pc = 32'h8000_2000;
        #1;
        chk("lit_adel2_code", exc_code, 5'h04);
        tick(); clr(); mfc0_addr = 5'd8;
        #1;
        chk("lit_adel2_epc_kept", epc_o, 32'h8000_1000);
        chk("lit_adel2_badv", mfc0_data, 32'h8000_0007);

        // eret with a coincident Status write
        wr0(5'd14, 32'hBFC0_2000);
        clr(); inst_valid = 1; eret = 1; mtc0_en = 1; mtc0_addr = 5'd12; mtc0_data = 32'hFFFF_FFFF;
        #1;
        chk("lit_eret2_target", pc_target, 32'hBFC0_2000);
        tick(); clr();
        chk("lit_eret2_status", status_o, 32'h0040_0000);

        // stalled syscall; Count keeps running
        wr0(5'd9, 32'd100);
        clr(); stall = 1; inst_valid = 1; sys = 1; mfc0_addr = 5'd9;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("lit_stall_no_exc", exc_valid, 0);
            tick();
        end
        stall = 0;
        #1;
        chk("lit_stall_count", mfc0_data, 32'd102);
        chk("lit_sys_code", exc_code, 5'h08);
        tick();
        do_eret();

        // external interrupt through the synchroniser beats ov
        wr0(5'd12, 32'h0000_0401);
        ext_int = 1;
        tick();
        ext_int = 0;
        chk("lit_ip10_early", cause_o[10], 0);
        tick();
        chk("lit_ip10_visible", cause_o[10], 1);
        inst_valid = 1; ov = 1; pc = 32'h8000_3000;
        #1;
        chk("lit_int_valid", exc_valid, 1);
        chk("lit_int_code", exc_code, 5'h00);
        tick();
        do_eret();

        // timer interrupt
        wr0(5'd12, 32'h0000_8001);
        wr0(5'd11, 32'd4);
        wr0(5'd9, 32'd0);
        waited = 0;
        found  = 0;
        for (int k = 0; k < 20; k++)
            if (!found) begin
                tick();
                waited++;
                if (timer_int) found = 1;
            end
        chk("lit_ti_seen", found, 1);
        chk("lit_ti_latency", (waited == 8 || waited == 9), 1);
        chk("lit_ti_cause_ip7", cause_o[15], 1);
        clr(); inst_valid = 1; pc = 32'h8000_4000;
        #1;
        chk("lit_ti_take", {exc_valid, exc_code}, {1'b1, 5'h00});
        tick();
        do_eret();
        wr0(5'd11, 32'h0000_0100);
        chk("lit_ti_cleared", timer_int, 0);

        // priority sweep, each with an mtc0 alongside
        wr0(5'd12, 32'h0);
        for (int k = 0; k < 8; k++) begin
            clr();
            inst_valid = 1;
            {adel_pc, adel_ld, ri, sys, brk, ades, ov, eret} = vec_tab[k];
            pc = 32'h8000_1000 + 32'(k * 16);
            badaddr = 32'h9000_0000 + 32'(k);
            in_delayslot = k[0];
            mtc0_en = 1; mtc0_addr = k[0] ? 5'd12 : 5'd14; mtc0_data = 32'h1234_5679;
            #1;
            chk("lit_prio_valid", exc_valid, val_tab[k]);
            chk("lit_prio_code", exc_code, code_tab[k]);
            tick();
            if (val_tab[k] && code_tab[k] != 5'h0E) do_eret();
        end
        clr();
        repeat (6) begin
            tick();
            clr();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter EXT_INT_W, default 6: number of external interrupt lines.
REQ-002 Parameter EXC_VECTOR, default 32'hBFC0_0380: general exception entry address.
REQ-003 Parameter SYNC_STAGES, default 2 (legal 1..3): flop stages on ext_int.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ext_int  in  EXT_INT_W  asynchronous hardware interrupt requests.
REQ-007 stall  in  1  M stage held; no exception commit, no CP0 write.
REQ-008 inst_valid  in  1  M stage holds a real instruction (not a bubble).
REQ-009 pc, badaddr  in  32 each  M-stage PC; load/store effective address.
REQ-010 in_delayslot  in  1  M instruction is a branch delay slot.
REQ-011 adel_pc, adel_ld, ades, ri, sys, brk, ov, eret  in  1 each  M-stage exception/eret flags.
REQ-012 mtc0_en  in  1; mtc0_addr  in  5; mtc0_data  in  32  CP0 write port.
REQ-013 mfc0_addr  in  5; mfc0_data  out  32  combinational CP0 read port.
REQ-014 exc_valid  out  1; exc_code  out  5; flush  out  1; pc_target  out  32  redirect.
REQ-015 status_o, cause_o, epc_o  out  32 each; timer_int  out  1.

Function
REQ-016 Registers implemented: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other addresses SHALL read 0 and ignore writes.
REQ-017 Status: IM[15:8], EXL[1], IE[0] writable; BEV[22] reads 1; other bits read 0.
REQ-018 Cause: IP[9:8] writable; BD[31], TI[30], IP[15:10], ExcCode[6:2] hardware-only; other bits 0.
REQ-019 Cause.IP[10+i] SHALL equal ext_int[i] after SYNC_STAGES cycles, i < min(EXT_INT_W,6); IP[15] additionally ORed with TI.
REQ-020 Count SHALL increment by 1 every second cycle (internal toggle flop), wrapping at 2^32-1 -> 0.
REQ-021 TI SHALL set on the cycle Count equals Compare and stay set until a Compare write, which clears it; timer_int = TI.
REQ-022 int_pending = IE & ~EXL & |(IM & IP).
REQ-023 Commit condition: inst_valid & ~stall; nothing is taken otherwise.
REQ-024 Priority on commit: interrupt(0x00) > adel_pc|adel_ld(0x04) > ri(0x0A) > sys(0x08) > brk(0x09) > ades(0x05) > ov(0x0C) > eret(0x0E).
REQ-025 exc_valid, flush, exc_code, pc_target SHALL be combinational from the current cycle; exc_code = 0 when none.
REQ-026 pc_target = EPC for eret, EXC_VECTOR for any other event, 0 when none.
REQ-027 On taken exception (not eret), next edge: EXL <= 1; ExcCode <= code; BD <= in_delayslot; EPC <= in_delayslot ? pc-4 : pc, unless EXL was already 1 (EPC, BD unchanged).
REQ-028 BadVAddr <= pc for adel_pc, badaddr for adel_ld or ades; unchanged otherwise.
REQ-029 On taken eret, next edge: EXL <= 0; no other register changes.
REQ-030 An mtc0 in the same cycle as a taken exception/eret SHALL be discarded.
REQ-031 mtc0 to Count SHALL load the value and suppress that cycle's increment; the toggle flop continues.
REQ-032 Simultaneous Count==Compare and Compare write: the write wins, TI = 0.
REQ-033 mfc0_data SHALL reflect register state before the current edge (no write bypass).
REQ-034 Counter toggle and Count SHALL advance during stall.

Reset
REQ-035 On rst: Status = 32'h0040_0000, Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, toggle = 0, sync flops = 0.
REQ-036 On rst, exc_valid, flush, exc_code, pc_target, timer_int = 0; rst in the middle of a stall or exception commit SHALL override all updates.

Verification
REQ-037 ri=1, pc=32'hBFC0_1000, in_delayslot=1 -> exc_code 0x0A, pc_target BFC0_0380, next cycle EPC BFC0_0FFC, BD=1, EXL=1.
REQ-038 Compare=4, Count=0, IE=1, IM[7]=1 -> TI sets when Count=4 (cycle 8 or 9 by toggle phase), next valid instruction takes code 0x00; write Compare clears TI.
REQ-039 ext_int[0]=1 for one cycle with IM[2]=1, IE=1 -> IP[10] visible SYNC_STAGES cycles later, interrupt then taken over simultaneous ov.
REQ-040 adel_ld=1, badaddr=32'h8000_0003 -> code 0x04, BadVAddr 8000_0003; repeat with EXL=1 -> EPC unchanged.
REQ-041 eret with EPC=32'hBFC0_2000 plus mtc0 to Status -> pc_target BFC0_2000, EXL 0, Status write discarded.
REQ-042 stall=1 with sys=1 -> exc_valid 0, Count still advances; release stall -> code 0x08.
